// File: rtl/jc_output_bcd.sv
// Output register stage feeding the display: latches the data bus on OI and
// converts it (signed or unsigned) to sign code + three BCD digits via double-dabble.
module jc_output_bcd #(
  parameter logic [4:0] SIGN_BLANK_CODE = 5'h15,
  parameter logic [4:0] SIGN_NEG_CODE   = 5'h16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  Data_Bus,
  input  logic        Output_Load,
  input  logic        Signed_Mode,
  output logic [16:0] CPU_Output,
  output logic [7:0]  Output_Raw,
  output logic        Busy,
  output logic        Output_Done
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned BCD_W   = 12;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned DIGITS  = 3;
  localparam int unsigned SCR_W   = BCD_W + DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                neg_q, neg_d;
  logic [16:0]         cpu_d;
  logic [DATA_W-1:0]   raw_d;
  logic                busy_d;
  logic                done_d;
  logic [BCD_W-1:0]    bcd_adj;
  logic [SCR_W-1:0]    scratch_sh;

  // Double-dabble iteration: add-3 on every digit >= 5, then shift the whole scratch left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = 4'(bcd_q[i*4 +: 4] + 4'd3);
      end
    end
    scratch_sh = {bcd_adj, mag_q} << 1;
  end

  // Next-state and next-output logic; a load always wins and restarts the conversion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    cpu_d   = CPU_Output;
    raw_d   = Output_Raw;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: ;
      ST_SHIFT: begin
        bcd_d = scratch_sh[SCR_W-1:DATA_W];
        mag_d = scratch_sh[DATA_W-1:0];
        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        cpu_d   = {(neg_q ? SIGN_NEG_CODE : SIGN_BLANK_CODE), bcd_q};
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (Output_Load) begin
      raw_d   = Data_Bus;
      neg_d   = Signed_Mode & Data_Bus[DATA_W-1];
      mag_d   = neg_d ? DATA_W'(~Data_Bus + DATA_W'(1)) : Data_Bus;
      bcd_d   = '0;
      cnt_d   = '0;
      state_d = ST_SHIFT;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mag_q       <= '0;
      bcd_q       <= '0;
      neg_q       <= 1'b0;
      CPU_Output  <= {SIGN_BLANK_CODE, 12'h000};
      Output_Raw  <= '0;
      Busy        <= 1'b0;
      Output_Done <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      neg_q       <= neg_d;
      CPU_Output  <= cpu_d;
      Output_Raw  <= raw_d;
      Busy        <= busy_d;
      Output_Done <= done_d;
    end
  end

endmodule

// File: tb/tb_jc_output_bcd.sv
// Directed bench for jc_output_bcd: hand-computed display codes, latency,
// abort/restart, back-to-back, reset mid-conversion and a full 0..255 sweep.
module tb_jc_output_bcd;

  logic        CLK;
  logic        RESET;
  logic [7:0]  Data_Bus;
  logic        Output_Load;
  logic        Signed_Mode;
  logic [16:0] CPU_Output;
  logic [7:0]  Output_Raw;
  logic        Busy;
  logic        Output_Done;

  int unsigned tests_run;
  int unsigned tests_failed;
  logic [16:0] cur_exp;

  jc_output_bcd dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .Data_Bus    (Data_Bus),
    .Output_Load (Output_Load),
    .Signed_Mode (Signed_Mode),
    .CPU_Output  (CPU_Output),
    .Output_Raw  (Output_Raw),
    .Busy        (Busy),
    .Output_Done (Output_Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decimal conversion, independent of the shift-add algorithm.
  function automatic logic [16:0] ref_code(input logic [7:0] d, input logic sm);
    int v;
    logic neg;
    neg = sm & d[7];
    v   = neg ? (256 - int'(d)) : int'(d);
    return {(neg ? 5'h16 : 5'h15), 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Single-cycle OI pulse, then watch 10 cycles for latency, pulse width and stability.
  task automatic convert(input logic [7:0] d, input logic sm, input logic [16:0] exp,
                         input string tag);
    int busy_cnt, done_cnt, done_k, unstable;
    @(negedge CLK);
    Data_Bus    = d;
    Signed_Mode = sm;
    Output_Load = 1'b1;
    @(negedge CLK);
    Output_Load = 1'b0;
    Data_Bus    = 8'($urandom);
    Signed_Mode = 1'($urandom);
    check({tag, "_raw"}, 32'(Output_Raw), 32'(d));
    busy_cnt = Busy ? 1 : 0;
    done_cnt = Output_Done ? 1 : 0;
    done_k   = 0;
    unstable = (CPU_Output !== cur_exp) ? 1 : 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (Busy) busy_cnt++;
      if (Output_Done) begin
        done_cnt++;
        done_k = k;
      end
      if (k < 9 && CPU_Output !== cur_exp) unstable++;
      if (k == 9) check({tag, "_cpu"}, 32'(CPU_Output), 32'(exp));
    end
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd9);
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_edge"}, 32'(done_k), 32'd9);
    check({tag, "_stable"}, 32'(unstable), 32'd0);
    cur_exp = exp;
  endtask

  initial begin
    int done_cnt, bad;
    tests_run    = 0;
    tests_failed = 0;
    RESET        = 1'b1;
    Data_Bus     = 8'h00;
    Output_Load  = 1'b0;
    Signed_Mode  = 1'b0;
    cur_exp      = 17'h15000;

    #12;
    check("reset_cpu",  32'(CPU_Output), 32'h15000);
    check("reset_raw",  32'(Output_Raw), 32'h0);
    check("reset_busy", 32'(Busy), 32'h0);
    check("reset_done", 32'(Output_Done), 32'h0);
    @(negedge CLK);
    RESET = 1'b0;

    convert(8'hFF, 1'b0, 17'h15255, "u_ff");
    convert(8'hFF, 1'b1, 17'h16001, "s_ff");
    convert(8'h80, 1'b1, 17'h16128, "s_80");
    convert(8'h7F, 1'b1, 17'h15127, "s_7f");
    convert(8'h00, 1'b1, 17'h15000, "s_00");
    convert(8'd42, 1'b0, 17'h15042, "u_42");

    // Restart: 42 loaded at N, 200 loaded at N+4 -> only one update, at N+13.
    @(negedge CLK);
    Data_Bus = 8'd42; Signed_Mode = 1'b0; Output_Load = 1'b1;
    @(negedge CLK);
    Output_Load = 1'b0;
    repeat (3) @(negedge CLK);
    Data_Bus = 8'd200; Output_Load = 1'b1;
    @(negedge CLK);
    Output_Load = 1'b0;
    check("abort_raw", 32'(Output_Raw), 32'd200);
    done_cnt = 0;
    bad = 0;
    for (int k = 5; k <= 14; k++) begin
      @(negedge CLK);
      if (Output_Done) done_cnt++;
      if (k < 13 && CPU_Output !== cur_exp) bad++;
      if (k == 13) begin
        check("abort_cpu", 32'(CPU_Output), 32'h15200);
        check("abort_done_edge", 32'(Output_Done), 32'h1);
      end
    end
    check("abort_hold", 32'(bad), 32'd0);
    check("abort_done_count", 32'(done_cnt), 32'd1);
    cur_exp = 17'h15200;

    // Load in DONE: result of 55 written and 0x80 signed captured on the same edge.
    @(negedge CLK);
    Data_Bus = 8'd55; Signed_Mode = 1'b0; Output_Load = 1'b1;
    @(negedge CLK);
    Output_Load = 1'b0;
    repeat (8) @(negedge CLK);
    Data_Bus = 8'h80; Signed_Mode = 1'b1; Output_Load = 1'b1;
    @(negedge CLK);
    Output_Load = 1'b0;
    check("b2b_first_cpu",  32'(CPU_Output), 32'h15055);
    check("b2b_first_done", 32'(Output_Done), 32'h1);
    check("b2b_busy_kept",  32'(Busy), 32'h1);
    check("b2b_raw",        32'(Output_Raw), 32'h80);
    repeat (8) @(negedge CLK);
    check("b2b_mid_done", 32'(Output_Done), 32'h0);
    check("b2b_mid_cpu",  32'(CPU_Output), 32'h15055);
    @(negedge CLK);
    check("b2b_second_cpu",  32'(CPU_Output), 32'h16128);
    check("b2b_second_done", 32'(Output_Done), 32'h1);
    check("b2b_second_busy", 32'(Busy), 32'h0);
    cur_exp = 17'h16128;
    repeat (2) @(negedge CLK);

    // Async reset mid-conversion: takes effect between edges, no completion afterwards.
    @(negedge CLK);
    Data_Bus = 8'd99; Signed_Mode = 1'b0; Output_Load = 1'b1;
    @(negedge CLK);
    Output_Load = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    check("rst_async_cpu",  32'(CPU_Output), 32'h15000);
    check("rst_async_busy", 32'(Busy), 32'h0);
    check("rst_async_raw",  32'(Output_Raw), 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    done_cnt = 0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (Output_Done) done_cnt++;
      if (CPU_Output !== 17'h15000) bad++;
    end
    check("rst_no_done", 32'(done_cnt), 32'd0);
    check("rst_cpu_held", 32'(bad), 32'd0);
    cur_exp = 17'h15000;

    // Full sweep in both modes against the reference conversion.
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 256; v++) begin
        convert(8'(v), 1'(m), ref_code(8'(v), 1'(m)), $sformatf("sweep_m%0d_v%0d", m, v));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/jc_output_bcd.md
Name: jc_output_bcd

Overview:
Output register stage directly upstream of the display block. It latches the 8-bit data bus when the OI control flag strobes and converts the value, signed or unsigned, to three BCD digits plus a sign code. Conversion uses a sequential double-dabble engine. It drives the display's 17-bit CPU_Output input, formatted as {5-bit sign code, hundreds, tens, ones}.

Parameters:
SIGN_BLANK_CODE, 5'h15, display code driven into CPU_Output[16:12] for non-negative results (blank segment).
SIGN_NEG_CODE, 5'h16, display code driven into CPU_Output[16:12] for negative results (minus sign).

Ports:
CLK  input  1  system clock, all state updates on rising edge.
RESET  input  1  asynchronous, active-high reset.
Data_Bus  input  8  shared CPU data bus.
Output_Load  input  1  OI control flag; Data_Bus is captured on any rising edge where it is high.
Signed_Mode  input  1  1 = treat captured value as two's complement; 0 = unsigned. Sampled with Output_Load.
CPU_Output  output  17  {sign code[16:12], hundreds[11:8], tens[7:4], ones[3:0]}, registered.
Output_Raw  output  8  last captured binary value, registered.
Busy  output  1  high while a conversion is in progress.
Output_Done  output  1  one-cycle pulse, coincident with the CPU_Output update.

Behaviour:
- Reset (asynchronous, effective immediately):
  - CPU_Output = {SIGN_BLANK_CODE, 12'h000} = 17'h15000.
  - Output_Raw = 0, Busy = 0, Output_Done = 0.
  - FSM = IDLE, shift counter = 0, scratch registers cleared.
- FSM states:
  - IDLE: Busy = 0. Output_Load = 1 → capture, go to SHIFT.
  - SHIFT: 8 iterations, one per clock. Each iteration, in order: (a) for each BCD nibble ≥ 5, add 3; (b) shift {bcd[11:0], mag[7:0]} left by 1. After the 8th iteration, go to DONE.
  - DONE: write CPU_Output, pulse Output_Done, return to IDLE.
- Capture (edge N):
  - Output_Raw ← Data_Bus.
  - neg ← Signed_Mode & Data_Bus[7].
  - mag ← neg ? (~Data_Bus + 1) : Data_Bus.
  - -128 (8'h80, signed) yields mag = 128; no overflow, since mag is unsigned 8-bit.
  - BCD scratch ← 0, counter ← 0.
- Latency:
  - Edges N+1..N+8 perform the shifts.
  - At edge N+9: CPU_Output ← {neg ? SIGN_NEG_CODE : SIGN_BLANK_CODE, bcd}; Output_Done = 1 for the cycle following N+9.
  - Busy = 1 from after edge N until edge N+9; Busy = 0 in the Output_Done cycle.
  - Back-to-back loads are accepted in that cycle.
- CPU_Output holds its previous value for the whole conversion; the display never shows partial digits.
- Digits are always valid BCD 0–9. Leading zeros are shown (no blanking). Max unsigned 255 → 2,5,5.
- Output_Load asserted during SHIFT: conversion aborts and restarts from the new capture at that edge (latest wins). Output_Raw updates immediately; the previous CPU_Output is retained until the restarted conversion completes.
- Output_Load asserted in DONE: CPU_Output is written with the finished result and the new value is captured on the same edge. FSM goes to SHIFT, not IDLE.
- Output_Load held high continuously: capture restarts every edge, so CPU_Output never updates. This is the required behaviour; the controller issues single-cycle OI pulses.
- Reset mid-conversion: all state returns to reset values; no Output_Done pulse.
- Signed_Mode and Data_Bus are ignored except at capture edges.

Test Plan:
- Reset asserted asynchronously between edges → CPU_Output = 17'h15000, Busy = 0 immediately, before the next edge.
- Unsigned load 8'hFF, one-cycle pulse → Busy high 9 cycles; CPU_Output = 17'h15255 at edge N+9; Output_Done high exactly one cycle; Output_Raw = 8'hFF from edge N.
- Signed load 8'hFF → 17'h16001. Signed 8'h80 → 17'h16128. Signed 8'h7F → 17'h15127. Signed 8'h00 → 17'h15000.
- Load 8'd42 unsigned, then load 8'd200 at edge N+4 → no update at N+9; CPU_Output = 17'h15200 at edge N+13; one Output_Done pulse total.
- Load 8'd99, assert RESET at edge N+5 → CPU_Output stays 17'h15000 after reset release; no Output_Done pulse.
- Exhaustive sweep of 0–255 in both modes with single-cycle pulses spaced 10 cycles apart → every CPU_Output matches the reference decimal conversion, and CPU_Output is stable during Busy.
